// File: rtl/echo_indication_pkg.sv
// Shared message layout and tags for the Echo indication marshaller.
package echo_indication_pkg;

  localparam int          ECHO_MSG_W = 96;
  localparam logic [31:0] TAG_HEARD  = 32'd1;
  localparam logic [31:0] TAG_HEARD2 = 32'd2;

  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] field0;
    logic [31:0] field1;
  } echo_msg_t;

  typedef enum logic {
    SRC_HEARD  = 1'b0,
    SRC_HEARD2 = 1'b1
  } echo_src_e;

endpackage

// File: rtl/echo_msg_fifo.sv
// Small circular message FIFO; head is presented combinationally and reads 0 when empty.
module echo_msg_fifo
  import echo_indication_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push,
  input  echo_msg_t i_data,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output echo_msg_t o_head
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = 1;
  localparam logic [AW:0]    CNT_ONE = 1;
  localparam logic [AW:0]    CNT_MAX = DEPTH[AW:0];

  echo_msg_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CNT_MAX);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/echo_indication_output.sv
// Packs heard/heard2 calls into tagged 96-bit messages, arbitrates them round-robin
// into a FIFO and drains the FIFO onto the outbound pipe.
module echo_indication_output
  import echo_indication_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        indication_heard__ENA,
  input  logic [31:0] indication_heard_meth,
  input  logic [31:0] indication_heard_v,
  output logic        indication_heard__RDY,
  input  logic        indication_heard2__ENA,
  input  logic [31:0] indication_heard2_a,
  input  logic [31:0] indication_heard2_b,
  output logic        indication_heard2__RDY,
  output logic        pipe_enq__ENA,
  output logic [95:0] pipe_enq_v,
  input  logic        pipe_enq__RDY,
  output logic [31:0] sent_count
);

  logic      r_h1_valid;
  echo_msg_t r_h1_msg;
  logic      r_h2_valid;
  echo_msg_t r_h2_msg;
  echo_src_e r_rr;
  logic [31:0] r_sent_count;

  logic      w_full;
  logic      w_empty;
  echo_msg_t w_head;
  echo_msg_t w_push_msg;
  logic      w_grant1;
  logic      w_grant2;
  logic      w_call1;
  logic      w_call2;
  logic      w_pop;

  // Grants look only at registered state, so RDY never depends on ENA.
  assign w_grant1 = !w_full && r_h1_valid && (!r_h2_valid || (r_rr == SRC_HEARD));
  assign w_grant2 = !w_full && r_h2_valid && (!r_h1_valid || (r_rr == SRC_HEARD2));

  assign indication_heard__RDY  = !r_h1_valid || w_grant1;
  assign indication_heard2__RDY = !r_h2_valid || w_grant2;

  assign w_call1 = indication_heard__ENA  && indication_heard__RDY;
  assign w_call2 = indication_heard2__ENA && indication_heard2__RDY;

  assign w_push_msg = w_grant1 ? r_h1_msg : r_h2_msg;

  assign pipe_enq__ENA = !w_empty;
  assign pipe_enq_v    = w_head;
  assign w_pop         = !w_empty && pipe_enq__RDY;
  assign sent_count    = r_sent_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_h1_valid   <= 1'b0;
      r_h1_msg     <= '0;
      r_h2_valid   <= 1'b0;
      r_h2_msg     <= '0;
      r_rr         <= SRC_HEARD;
      r_sent_count <= '0;
    end else begin
      // A call in the grant cycle reloads the holder instead of clearing it.
      if (w_call1) begin
        r_h1_valid <= 1'b1;
        r_h1_msg   <= '{tag: TAG_HEARD, field0: indication_heard_meth,
                        field1: indication_heard_v};
      end else if (w_grant1) begin
        r_h1_valid <= 1'b0;
      end

      if (w_call2) begin
        r_h2_valid <= 1'b1;
        r_h2_msg   <= '{tag: TAG_HEARD2, field0: indication_heard2_a,
                        field1: indication_heard2_b};
      end else if (w_grant2) begin
        r_h2_valid <= 1'b0;
      end

      if (!w_full && r_h1_valid && r_h2_valid) begin
        r_rr <= (r_rr == SRC_HEARD) ? SRC_HEARD2 : SRC_HEARD;
      end

      if (w_pop) begin
        r_sent_count <= r_sent_count + 32'd1;
      end
    end
  end

  echo_msg_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_push (w_grant1 || w_grant2),
    .i_data (w_push_msg),
    .i_pop  (w_pop),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (w_head)
  );

endmodule

// File: tb/tb_echo_indication_output.sv
// Bench for echo_indication_output: directed vector table, hand sequences and
// randomized traffic checked against a queue-based reference model.
module tb_echo_indication_output;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        e1 = 1'b0, e2 = 1'b0, prdy = 1'b0;
  logic [31:0] im = '0, iv = '0, ia = '0, ib = '0;
  logic        rdy1, rdy2, pena;
  logic [95:0] pv;
  logic [31:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  echo_indication_output #(.DEPTH(DEPTH)) dut (
    .CLK                    (clk),
    .RST                    (rst),
    .indication_heard__ENA  (e1),
    .indication_heard_meth  (im),
    .indication_heard_v     (iv),
    .indication_heard__RDY  (rdy1),
    .indication_heard2__ENA (e2),
    .indication_heard2_a    (ia),
    .indication_heard2_b    (ib),
    .indication_heard2__RDY (rdy2),
    .pipe_enq__ENA          (pena),
    .pipe_enq_v             (pv),
    .pipe_enq__RDY          (prdy),
    .sent_count             (cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending call per method, a message queue and a fairness pointer.
  bit          m_pend [2];
  logic [63:0] m_args [2];
  int          m_next;          // method that wins a tie next
  logic [95:0] m_q [$];
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0;
    m_next = 0;
    m_q.delete();
    m_cnt = '0;
  endtask

  function automatic int m_winner();
    if (m_q.size() >= DEPTH) return -1;
    if (m_pend[0] && m_pend[1]) return m_next;
    if (m_pend[0]) return 0;
    if (m_pend[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_rdy(int k);
    return !m_pend[k] || (m_winner() == k);
  endfunction

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_check(string tag);
    chk({tag, "_ena"}, 96'(pena), 96'(m_q.size() != 0));
    chk({tag, "_msg"}, pv, (m_q.size() != 0) ? m_q[0] : 96'd0);
    chk({tag, "_rdy1"}, 96'(rdy1), 96'(m_rdy(0)));
    chk({tag, "_rdy2"}, 96'(rdy2), 96'(m_rdy(1)));
    chk({tag, "_cnt"}, 96'(cnt), 96'(m_cnt));
  endtask

  // Drive one cycle of inputs (called just after a negedge), advance model at the edge.
  task automatic step(bit s_e1, logic [31:0] s_m, logic [31:0] s_v,
                      bit s_e2, logic [31:0] s_a, logic [31:0] s_b, bit s_p);
    int  w;
    bit  tie;
    bit  r0, r1;
    e1 = s_e1; im = s_m; iv = s_v;
    e2 = s_e2; ia = s_a; ib = s_b;
    prdy = s_p;
    @(posedge clk);
    w   = m_winner();
    tie = m_pend[0] && m_pend[1];
    r0  = m_rdy(0);
    r1  = m_rdy(1);
    if (m_q.size() != 0 && s_p) begin
      void'(m_q.pop_front());
      m_cnt = m_cnt + 32'd1;
    end
    if (w >= 0) begin
      m_q.push_back({(w == 0) ? 32'd1 : 32'd2, m_args[w]});
      m_pend[w] = 0;
      if (tie) m_next = 1 - w;
    end
    if (s_e1 && r0) begin m_pend[0] = 1; m_args[0] = {s_m, s_v}; end
    if (s_e2 && r1) begin m_pend[1] = 1; m_args[1] = {s_a, s_b}; end
    @(negedge clk);
  endtask

  typedef struct {
    bit          e1;
    logic [31:0] m, v;
    bit          e2;
    logic [31:0] a, b;
    bit          x_ena;
    logic [95:0] x_v;
    bit          x_r1, x_r2;
    logic [31:0] x_cnt;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(bit e1_, logic [31:0] m_, logic [31:0] v_,
                              bit e2_, logic [31:0] a_, logic [31:0] b_,
                              bit xe, logic [95:0] xv, bit xr1, bit xr2,
                              logic [31:0] xc);
    vec_t r;
    r.e1 = e1_; r.m = m_; r.v = v_; r.e2 = e2_; r.a = a_; r.b = b_;
    r.x_ena = xe; r.x_v = xv; r.x_r1 = xr1; r.x_r2 = xr2; r.x_cnt = xc;
    return r;
  endfunction

  initial begin
    logic [95:0] msg_h12;
    logic [95:0] msg_h234;
    logic [31:0] cnt_start;
    int          tries;
    bit          acc;

    msg_h12  = {32'd1, 32'd1, 32'd2};
    msg_h234 = {32'd2, 32'd3, 32'd4};
    // expectations are those seen before the row's inputs are applied
    tbl[0]  = mk(1, 5, 32'h1234, 0, 0, 0, 0, 96'd0, 1, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 96'd0, 1, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 96'h00000001_00000005_00001234, 1, 1, 0);
    tbl[3]  = mk(1, 1, 2, 1, 3, 4, 0, 96'd0, 1, 1, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 96'd0, 1, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, msg_h12, 1, 1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, msg_h234, 1, 1, 2);
    tbl[7]  = mk(1, 1, 2, 1, 3, 4, 0, 96'd0, 1, 1, 3);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 96'd0, 0, 1, 3);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, msg_h234, 1, 1, 3);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, msg_h12, 1, 1, 4);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 96'd0, 1, 1, 5);

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tbl%0d_ena", i), 96'(pena), 96'(tbl[i].x_ena));
      chk($sformatf("tbl%0d_msg", i), pv, tbl[i].x_v);
      chk($sformatf("tbl%0d_rdy1", i), 96'(rdy1), 96'(tbl[i].x_r1));
      chk($sformatf("tbl%0d_rdy2", i), 96'(rdy2), 96'(tbl[i].x_r2));
      chk($sformatf("tbl%0d_cnt", i), 96'(cnt), 96'(tbl[i].x_cnt));
      step(tbl[i].e1, tbl[i].m, tbl[i].v, tbl[i].e2, tbl[i].a, tbl[i].b, 1'b1);
    end

    // Backpressure: five calls fill FIFO plus holder, sixth waits for space.
    cnt_start = cnt;
    for (int v = 0; v < 5; v++) begin
      model_check("bp_fill");
      step(1, 32'h7, 32'(v), 0, 0, 0, 1'b0);
    end
    chk("bp_rdy_low", 96'(rdy1), 96'd0);
    chk("bp_head_v0", pv, {32'd1, 32'h7, 32'd0});
    model_check("bp_ignored");
    step(1, 32'h7, 32'd5, 0, 0, 0, 1'b0);   // ENA without RDY is dropped
    acc = 0;
    tries = 0;
    while (!acc && tries < 10) begin
      model_check("bp_wait");
      acc = m_rdy(0);
      step(1, 32'h7, 32'd5, 0, 0, 0, 1'b1);
      tries++;
    end
    chk("bp_call6_accepted", 96'(acc), 96'd1);
    for (int c = 0; c < 12; c++) begin
      model_check("bp_drain");
      step(0, 0, 0, 0, 0, 0, 1'b1);
    end
    chk("bp_delivered6", 96'(cnt - cnt_start), 96'd6);

    // Reset with three messages queued under backpressure.
    for (int v = 0; v < 3; v++) step(1, 32'h9, 32'(10 + v), 0, 0, 0, 1'b0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 1'b0);
    chk("rst_pre_ena", 96'(pena), 96'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_ena", 96'(pena), 96'd0);
    chk("rst_msg", pv, 96'd0);
    chk("rst_rdy1", 96'(rdy1), 96'd1);
    chk("rst_rdy2", 96'(rdy2), 96'd1);
    chk("rst_cnt", 96'(cnt), 96'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      model_check("rst_after");
      step(0, 0, 0, 0, 0, 0, 1'b1);
    end

    // Counter wrap.
    force dut.r_sent_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_sent_count;
    m_cnt = 32'hFFFF_FFFF;
    model_check("wrap_pre");
    step(1, 32'hA, 32'hB, 0, 0, 0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      model_check("wrap");
      step(0, 0, 0, 0, 0, 0, 1'b1);
    end
    chk("wrap_cnt0", 96'(cnt), 96'd0);

    // Randomized traffic, including occasional calls without RDY.
    for (int c = 0; c < 2000; c++) begin
      model_check("rnd");
      step(($urandom % 3) != 0, $urandom, $urandom,
           ($urandom % 3) != 0, $urandom, $urandom,
           (c % 200 < 120) ? (($urandom % 4) != 0) : (($urandom % 4) == 0));
    end
    for (int c = 0; c < 10; c++) begin
      model_check("final_drain");
      step(0, 0, 0, 0, 0, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/echo_indication_output.md
# echo_indication_output

Transmit-side marshaller for the Echo indication interface. It accepts `heard(meth, v)` and `heard2(a, b)` method calls from the Echo core and packs each call into a tagged 96-bit message. Messages are buffered in a small FIFO and emitted on an outbound `pipe$enq` port toward the portal/transport layer. It is the encoding counterpart of the request-side decoder that turns tagged pipe messages back into method calls.

## Interface
Parameters:
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.

Ports:
- `CLK`, input, 1: sole clock; all state updates on posedge.
- `RST`, input, 1: asynchronous, active-high reset.
- `indication$heard__ENA`, input, 1: heard call strobe.
- `indication$heard$meth`, input, 32: heard argument `meth`.
- `indication$heard$v`, input, 32: heard argument `v`.
- `indication$heard__RDY`, output, 1: heard may be called this cycle.
- `indication$heard2__ENA`, input, 1: heard2 call strobe.
- `indication$heard2$a`, input, 32: heard2 argument `a`.
- `indication$heard2$b`, input, 32: heard2 argument `b`.
- `indication$heard2__RDY`, output, 1: heard2 may be called this cycle.
- `pipe$enq__ENA`, output, 1: message valid.
- `pipe$enq$v`, output, 96: message: [95:64] tag, [63:32] field0, [31:0] field1.
- `pipe$enq__RDY`, input, 1: downstream accepts.
- `sent_count`, output, 32: messages delivered since reset.

## Operation
- Tags: `TAG_HEARD` = 1 (field0 = meth, field1 = v), `TAG_HEARD2` = 2 (field0 = a, field1 = b). Tag 0 is never emitted.
- Holding registers: one per method, each with a valid bit.
  - A call (ENA && RDY) captures the args and sets valid.
  - ENA without RDY is a caller protocol error. The block ignores it.
- Arbiter:
  - Each cycle with FIFO not full (registered `full`), grant one valid holder.
  - If both holders are valid, grant the one pointed to by `rr`. After that grant, `rr` points to the other holder.
  - If only one is valid, grant it. `rr` is unchanged.
  - The granted holder's message is written to the FIFO and its valid bit clears, unless the same method is called in that cycle, in which case it reloads.
- `heard__RDY` = !heard_valid || grant_heard. `heard2__RDY` is defined the same way. Grants depend only on registered state, so there is no ENA→RDY combinational path.
- FIFO:
  - `pipe$enq__ENA` = !empty.
  - `pipe$enq$v` = head entry, or 0 when empty.
  - Pop on ENA && RDY; `sent_count` increments by 1 on each pop and wraps modulo 2^32.
- Full FIFO: no write, even if a pop occurs in the same cycle. The write happens on the next cycle. Empty FIFO with a simultaneous write: no bypass.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Reset values (async, immediate):
  - Holder valids = 0, FIFO empty, `rr` = heard, `sent_count` = 0.
  - Therefore `pipe$enq__ENA` = 0, `pipe$enq$v` = 0, both RDYs = 1.
- Latency: call at edge N → holder valid after N → FIFO write at edge N+1 → `pipe$enq__ENA` high in cycle N+1..N+2 (visible after edge N+1). Minimum 2 edges call-to-output.
- Throughput:
  - One message per cycle into the FIFO and one out.
  - A single method can be called every cycle while the FIFO is not full.
  - With both methods active, each sustains 1 call per 2 cycles.
- Reset asserted mid-operation discards holders and FIFO contents. No partial message is emitted after reset deasserts.

## Structure
- Package `echo_indication_pkg` holds:
  - `TAG_HEARD`, `TAG_HEARD2`;
  - `ECHO_MSG_W` = 96;
  - packed struct `echo_msg_t` {tag, field0, field1}.
- Sub-module `echo_msg_fifo` (parameter DEPTH; ports push/data, pop, full/empty, head) is instantiated once.
- Arbiter, holders and `sent_count` live in the top.

## Test plan
- Reset, then `heard(meth=5, v=0x1234)` with `pipe$enq__RDY` = 1 → exactly one message 0x00000001_00000005_00001234 two edges later; `sent_count` = 1.
- Same-cycle `heard(1,2)` and `heard2(3,4)` after reset → order is tag1 then tag2. Repeat both → order is tag2 then tag1 (round-robin alternation).
- `pipe$enq__RDY` = 0, issue 6 heard calls with v = 0..5, DEPTH = 4 → FIFO holds 4, holder holds 1, `heard__RDY` = 0. Release RDY → messages v = 0..4 delivered in order, call 6 accepted once RDY is seen.
- FIFO full with pop and arbiter request in the same cycle → no write that cycle, write on the next; no message lost or duplicated.
- Assert `RST` while 3 messages are queued and `pipe$enq__RDY` = 0 → `pipe$enq__ENA` drops immediately, RDYs = 1, `sent_count` = 0, nothing emitted afterward.
- Force `sent_count` to 0xFFFFFFFF, deliver one message → `sent_count` = 0.
